// File: rtl/pcm_mm_pkg.sv
// Shared types and constants for the PCM main-memory arbiter.
package pcm_mm_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT_RD = 2'd2,
    DONE    = 2'd3
  } pcm_mm_state_t;

  localparam int DEF_NUM_PORTS  = 4;
  localparam int DEF_ADDR_W     = 20;
  localparam int DEF_DATA_W     = 16;
  localparam int DEF_RD_LATENCY = 1;

  // Width needed to index n items; never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pcm_mm_rr_arbiter.sv
// Round-robin arbiter: the lowest requesting index strictly above the last
// granted one wins, wrapping at NUM_PORTS. The pointer moves only on advance.
module pcm_mm_rr_arbiter
  import pcm_mm_pkg::*;
#(
  parameter int NUM_PORTS = DEF_NUM_PORTS,
  localparam int IDX_W = idx_width(NUM_PORTS)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_PORTS-1:0] req,
  input  logic                 advance,
  output logic [NUM_PORTS-1:0] grant,
  output logic [IDX_W-1:0]     grant_idx
);

  logic [IDX_W-1:0] last_reg;
  logic             found;
  int               cand;

  // Scan candidates starting just above the last grant.
  always_comb begin
    found     = 1'b0;
    grant_idx = '0;
    cand      = 0;
    for (int k = 1; k <= NUM_PORTS; k++) begin
      cand = int'(last_reg) + k;
      if (cand >= NUM_PORTS) cand = cand - NUM_PORTS;
      if (!found && req[IDX_W'(cand)]) begin
        found     = 1'b1;
        grant_idx = IDX_W'(cand);
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_PORTS; gi++) begin : g_onehot
      assign grant[gi] = found && (grant_idx == IDX_W'(gi));
    end
  endgenerate

  // Pointer starts at the top port so port 0 wins first after reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_reg <= IDX_W'(NUM_PORTS - 1);
    end else if (advance && found) begin
      last_reg <= grant_idx;
    end
  end

endmodule

// File: rtl/pcm_mm_arbiter.sv
// N-port arbiter in front of the single Avalon-MM port of PCM main memory.
// One transaction at a time: IDLE -> ISSUE -> (WAIT_RD) -> DONE -> IDLE.
module pcm_mm_arbiter
  import pcm_mm_pkg::*;
#(
  parameter int NUM_PORTS  = DEF_NUM_PORTS,
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int RD_LATENCY = DEF_RD_LATENCY
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [NUM_PORTS-1:0]            cpu_req,
  input  logic [NUM_PORTS-1:0]            cpu_write,
  input  logic [NUM_PORTS*ADDR_W-1:0]     cpu_addr,
  input  logic [NUM_PORTS*DATA_W-1:0]     cpu_wdata,
  input  logic [NUM_PORTS*DATA_W/8-1:0]   cpu_byteen,
  output logic [NUM_PORTS-1:0]            cpu_ready,
  output logic [NUM_PORTS*DATA_W-1:0]     cpu_rdata,
  output logic                            busy,
  output logic [ADDR_W-1:0]               pcm_mem_mm_address,
  output logic                            pcm_mem_mm_chipselect,
  output logic                            pcm_mem_mm_clken,
  output logic                            pcm_mem_mm_write,
  output logic [DATA_W-1:0]               pcm_mem_mm_writedata,
  output logic [DATA_W/8-1:0]             pcm_mem_mm_byteenable,
  input  logic [DATA_W-1:0]               pcm_mem_mm_readdata
);

  localparam int IDX_W = idx_width(NUM_PORTS);
  localparam int BE_W  = DATA_W / 8;
  localparam int CNT_W = idx_width(RD_LATENCY);

  generate
    if (NUM_PORTS < 2) begin : g_chk_ports
      $error("pcm_mm_arbiter: NUM_PORTS must be at least 2");
    end
    if (RD_LATENCY < 1) begin : g_chk_lat
      $error("pcm_mm_arbiter: RD_LATENCY must be at least 1");
    end
    if (DATA_W % 8 != 0) begin : g_chk_dw
      $error("pcm_mm_arbiter: DATA_W must be a multiple of 8");
    end
  endgenerate

  pcm_mm_state_t state_reg, state_next;

  logic [NUM_PORTS-1:0] arb_grant;
  logic [IDX_W-1:0]     arb_idx;
  logic                 advance;

  logic [NUM_PORTS-1:0] grant_oh_reg;
  logic [IDX_W-1:0]     grant_idx_reg;
  logic                 write_reg;
  logic [ADDR_W-1:0]    addr_reg;
  logic [DATA_W-1:0]    wdata_reg;
  logic [BE_W-1:0]      byteen_reg;
  logic [CNT_W-1:0]     cnt_reg;
  logic                 cnt_last;

  logic [ADDR_W-1:0] addr_arr   [NUM_PORTS];
  logic [DATA_W-1:0] wdata_arr  [NUM_PORTS];
  logic [BE_W-1:0]   byteen_arr [NUM_PORTS];

  assign advance  = (state_reg == IDLE) && (|cpu_req);
  assign cnt_last = (cnt_reg == CNT_W'(RD_LATENCY - 1));

  pcm_mm_rr_arbiter #(
    .NUM_PORTS(NUM_PORTS)
  ) u_rr (
    .clk      (clk),
    .reset    (reset),
    .req      (cpu_req),
    .advance  (advance),
    .grant    (arb_grant),
    .grant_idx(arb_idx)
  );

  genvar gi;
  generate
    for (gi = 0; gi < NUM_PORTS; gi++) begin : g_port
      logic [DATA_W-1:0] rdata_reg;

      assign addr_arr[gi]   = cpu_addr[gi*ADDR_W +: ADDR_W];
      assign wdata_arr[gi]  = cpu_wdata[gi*DATA_W +: DATA_W];
      assign byteen_arr[gi] = cpu_byteen[gi*BE_W +: BE_W];
      assign cpu_rdata[gi*DATA_W +: DATA_W] = rdata_reg;

      // Capture memory read data on the last latency cycle for the granted port only.
      always_ff @(posedge clk) begin
        if (reset) begin
          rdata_reg <= '0;
        end else if ((state_reg == WAIT_RD) && cnt_last &&
                     (grant_idx_reg == IDX_W'(gi))) begin
          rdata_reg <= pcm_mem_mm_readdata;
        end
      end
    end
  endgenerate

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      IDLE:    if (|cpu_req) state_next = ISSUE;
      ISSUE:   state_next = write_reg ? DONE : WAIT_RD;
      WAIT_RD: if (cnt_last) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Latch the winning port's transaction so it completes even if req drops.
  always_ff @(posedge clk) begin
    if (reset) begin
      grant_oh_reg  <= '0;
      grant_idx_reg <= '0;
      write_reg     <= 1'b0;
      addr_reg      <= '0;
      wdata_reg     <= '0;
      byteen_reg    <= '0;
    end else if (advance) begin
      grant_oh_reg  <= arb_grant;
      grant_idx_reg <= arb_idx;
      write_reg     <= cpu_write[arb_idx];
      addr_reg      <= addr_arr[arb_idx];
      wdata_reg     <= wdata_arr[arb_idx];
      byteen_reg    <= byteen_arr[arb_idx];
    end
  end

  // Read latency counter: cleared during ISSUE, counts through WAIT_RD.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_reg <= '0;
    end else if (state_reg == ISSUE) begin
      cnt_reg <= '0;
    end else if (state_reg == WAIT_RD) begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  // Memory strobes only during ISSUE; ready pulse only during DONE.
  always_comb begin
    busy                  = (state_reg != IDLE);
    cpu_ready             = '0;
    pcm_mem_mm_address    = '0;
    pcm_mem_mm_chipselect = 1'b0;
    pcm_mem_mm_clken      = 1'b0;
    pcm_mem_mm_write      = 1'b0;
    pcm_mem_mm_writedata  = '0;
    pcm_mem_mm_byteenable = '0;
    if (state_reg == ISSUE) begin
      pcm_mem_mm_address    = addr_reg;
      pcm_mem_mm_chipselect = 1'b1;
      pcm_mem_mm_clken      = 1'b1;
      pcm_mem_mm_write      = write_reg;
      pcm_mem_mm_writedata  = wdata_reg;
      pcm_mem_mm_byteenable = byteen_reg;
    end
    if (state_reg == DONE) begin
      cpu_ready = grant_oh_reg;
    end
  end

endmodule

// File: tb/tb_pcm_mm_arbiter.sv
// Self-checking bench for pcm_mm_arbiter with a latency-RL memory model.
module tb_pcm_mm_arbiter;

  localparam int NP = 4;
  localparam int AW = 20;
  localparam int DW = 16;
  localparam int BW = DW / 8;
  localparam int RL = 2;

  logic              clk = 1'b0;
  logic              reset;
  logic [NP-1:0]     cpu_req;
  logic [NP-1:0]     cpu_write;
  logic [NP*AW-1:0]  cpu_addr;
  logic [NP*DW-1:0]  cpu_wdata;
  logic [NP*BW-1:0]  cpu_byteen;
  logic [NP-1:0]     cpu_ready;
  logic [NP*DW-1:0]  cpu_rdata;
  logic              busy;
  logic [AW-1:0]     mm_address;
  logic              mm_chipselect, mm_clken, mm_write;
  logic [DW-1:0]     mm_writedata;
  logic [BW-1:0]     mm_byteenable;
  logic [DW-1:0]     mm_readdata;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    int          port;
    logic [15:0] rdata;
  } exp_t;
  exp_t exp_q[$];

  typedef struct {
    int          port;
    bit          wr;
    logic [19:0] addr;
    logic [15:0] wdata;
    logic [1:0]  be;
    logic [15:0] exp_rd;
  } vec_t;

  logic [15:0] last_rd [NP];

  always #5 clk = ~clk;

  pcm_mm_arbiter #(
    .NUM_PORTS(NP), .ADDR_W(AW), .DATA_W(DW), .RD_LATENCY(RL)
  ) dut (
    .clk                  (clk),
    .reset                (reset),
    .cpu_req              (cpu_req),
    .cpu_write            (cpu_write),
    .cpu_addr             (cpu_addr),
    .cpu_wdata            (cpu_wdata),
    .cpu_byteen           (cpu_byteen),
    .cpu_ready            (cpu_ready),
    .cpu_rdata            (cpu_rdata),
    .busy                 (busy),
    .pcm_mem_mm_address   (mm_address),
    .pcm_mem_mm_chipselect(mm_chipselect),
    .pcm_mem_mm_clken     (mm_clken),
    .pcm_mem_mm_write     (mm_write),
    .pcm_mem_mm_writedata (mm_writedata),
    .pcm_mem_mm_byteenable(mm_byteenable),
    .pcm_mem_mm_readdata  (mm_readdata)
  );

  // Memory model: 256 words preset to 0x5A5A, byte-enabled writes, RL-deep read pipe.
  logic [15:0] mem [256];
  logic [15:0] rd_pipe [RL];
  bit          mem_ready;
  assign mm_readdata = rd_pipe[RL-1];

  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int i = 0; i < 256; i++) mem[i] <= 16'h5A5A;
      mem_ready <= 1'b1;
    end else if (mm_chipselect && mm_clken && mm_write) begin
      if (mm_byteenable[0]) mem[mm_address[7:0]][7:0]  <= mm_writedata[7:0];
      if (mm_byteenable[1]) mem[mm_address[7:0]][15:8] <= mm_writedata[15:8];
    end
    rd_pipe[0] <= (mm_chipselect && mm_clken && !mm_write) ? mem[mm_address[7:0]] : 16'hDEAD;
    for (int i = 1; i < RL; i++) rd_pipe[i] <= rd_pipe[i-1];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: actual %h required %h", name, act, req);
    end
  endtask

  // Scoreboard: every ready pulse pops the next expected completion.
  always @(negedge clk) begin
    exp_t e;
    if (!reset && cpu_ready != '0) begin
      chk("ready_onehot", $countones(cpu_ready), 1);
      for (int p = 0; p < NP; p++) begin
        if (cpu_ready[p]) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_ready: actual ready on port %0d, required none", p);
          end else begin
            e = exp_q.pop_front();
            chk("grant_port", p, e.port);
            chk("rdata", {16'h0, cpu_rdata[p*DW +: DW]}, {16'h0, e.rdata});
            $display("txn done port %0d rdata %h at %0t", p, cpu_rdata[p*DW +: DW], $time);
          end
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: actual simulation still running, required finish");
    $fatal(1, "watchdog");
  end

  task automatic set_port(input int p, input bit w, input logic [19:0] a,
                          input logic [15:0] d, input logic [1:0] be);
    cpu_write[p]          = w;
    cpu_addr[p*AW +: AW]  = a;
    cpu_wdata[p*DW +: DW] = d;
    cpu_byteen[p*BW +: BW] = be;
  endtask

  task automatic do_reset();
    chk("scoreboard_drained", exp_q.size(), 0);
    @(posedge clk); #1;
    reset   = 1'b1;
    cpu_req = '0;
    @(posedge clk); #1;
    reset = 1'b0;
    for (int p = 0; p < NP; p++) last_rd[p] = '0;
  endtask

  // One transaction with cycle-exact checks of ISSUE strobes and ready timing.
  task automatic run_timed(input vec_t v);
    exp_t e;
    int   lat;
    lat     = v.wr ? 2 : 2 + RL;
    e.port  = v.port;
    if (!v.wr) last_rd[v.port] = v.exp_rd;
    e.rdata = last_rd[v.port];
    exp_q.push_back(e);
    @(posedge clk); #1;
    set_port(v.port, v.wr, v.addr, v.wdata, v.be);
    cpu_req[v.port] = 1'b1;
    @(negedge clk);
    chk("busy_idle", busy, 0);
    for (int c = 1; c <= lat; c++) begin
      @(negedge clk);
      if (c == 1) begin
        chk("issue_cs", mm_chipselect, 1);
        chk("issue_clken", mm_clken, 1);
        chk("issue_write", mm_write, v.wr);
        chk("issue_addr", mm_address, v.addr);
        chk("issue_wdata", mm_writedata, v.wdata);
        chk("issue_be", mm_byteenable, v.be);
      end else begin
        chk("strobe_off", {mm_chipselect, mm_clken, mm_write}, 0);
      end
      chk("ready_timing", cpu_ready[v.port], (c == lat));
    end
    @(posedge clk); #1;
    cpu_req[v.port] = 1'b0;
    @(negedge clk);
    chk("busy_after", busy, 0);
    for (int p = 0; p < NP; p++)
      chk("rdata_hold", {16'h0, cpu_rdata[p*DW +: DW]}, {16'h0, last_rd[p]});
  endtask

  // Several ports request; order is checked by the scoreboard, spacing here.
  task automatic group_run(input logic [NP-1:0] mask, input bit hold,
                           input int n_txn, input int gap);
    int seen, cycles, last_cyc;
    logic [NP-1:0] drop;
    seen = 0; cycles = 0; last_cyc = -1;
    @(posedge clk); #1;
    cpu_req = cpu_req | mask;
    while (seen < n_txn && cycles < 300) begin
      @(negedge clk);
      cycles++;
      if ((cpu_ready & mask) != '0) begin
        if (last_cyc >= 0) chk("ready_spacing", cycles - last_cyc, gap);
        last_cyc = cycles;
        seen++;
        drop = hold ? ((seen == n_txn) ? mask : '0) : (cpu_ready & mask);
        @(posedge clk); #1;
        cpu_req = cpu_req & ~drop;
      end
    end
    if (seen < n_txn) begin
      n_checks++;
      n_errors++;
      $display("FAIL group_timeout: actual %0d completions, required %0d", seen, n_txn);
      cpu_req = cpu_req & ~mask;
    end
  endtask

  vec_t vecs [9];
  exp_t e0;

  initial begin
    reset = 1'b1; cpu_req = '0; cpu_write = '0;
    cpu_addr = '0; cpu_wdata = '0; cpu_byteen = '0;
    for (int p = 0; p < NP; p++) last_rd[p] = '0;

    vecs[0] = '{0, 1'b1, 20'h00010, 16'hBEEF, 2'b11, 16'h0000};
    vecs[1] = '{1, 1'b0, 20'h00010, 16'h0000, 2'b11, 16'hBEEF};
    vecs[2] = '{2, 1'b1, 20'h00020, 16'h12AB, 2'b01, 16'h0000};
    vecs[3] = '{2, 1'b0, 20'h00020, 16'h0000, 2'b11, 16'h5AAB};
    vecs[4] = '{3, 1'b1, 20'hFFFFF, 16'h1234, 2'b10, 16'h0000};
    vecs[5] = '{3, 1'b0, 20'hFFFFF, 16'h0000, 2'b11, 16'h125A};
    vecs[6] = '{0, 1'b0, 20'h00020, 16'h0000, 2'b11, 16'h5AAB};
    vecs[7] = '{1, 1'b1, 20'h00010, 16'h7777, 2'b00, 16'h0000};
    vecs[8] = '{0, 1'b0, 20'h00010, 16'h0000, 2'b11, 16'hBEEF};

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_ready", cpu_ready, 0);
    chk("rst_rdata_lo", cpu_rdata[31:0], 0);
    chk("rst_rdata_hi", cpu_rdata[63:32], 0);
    chk("rst_strobes", {mm_chipselect, mm_clken, mm_write}, 0);
    chk("rst_addr", mm_address, 0);
    chk("rst_wdata", mm_writedata, 0);
    chk("rst_be", mm_byteenable, 0);

    // Table-driven single transactions: write, read-back, byte enables, top address.
    for (int i = 0; i < 9; i++) run_timed(vecs[i]);

    // All four ports at once after reset: grants 0,1,2,3, readies 3 cycles apart.
    do_reset();
    for (int p = 0; p < NP; p++) begin
      set_port(p, 1'b1, 20'h00040 + 20'(p), 16'h1000 + 16'(p), 2'b11);
      e0.port = p; e0.rdata = 16'h0000;
      exp_q.push_back(e0);
    end
    group_run(4'b1111, 1'b0, 4, 3);

    // Fairness: ports 0 and 3 hold req; grants alternate 0,3,0,3...
    do_reset();
    set_port(0, 1'b1, 20'h00050, 16'hAAAA, 2'b11);
    set_port(3, 1'b1, 20'h00053, 16'hBBBB, 2'b11);
    for (int i = 0; i < 8; i++) begin
      e0.port = (i % 2 == 0) ? 0 : 3; e0.rdata = 16'h0000;
      exp_q.push_back(e0);
    end
    group_run(4'b1001, 1'b1, 8, 3);

    // Reset during WAIT_RD: no ready for the aborted read, port 3 then port 0.
    set_port(1, 1'b0, 20'h00010, 16'h0000, 2'b11);
    @(posedge clk); #1;
    cpu_req[1] = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("abort_issue_cs", mm_chipselect, 1);
    @(posedge clk); #1;
    reset = 1'b1;
    cpu_req[1] = 1'b0;
    @(negedge clk);
    chk("abort_busy_wait", busy, 1);
    @(posedge clk); #1;
    reset = 1'b0;
    for (int p = 0; p < NP; p++) last_rd[p] = '0;
    @(negedge clk);
    chk("abort_busy", busy, 0);
    chk("abort_strobes", {mm_chipselect, mm_clken, mm_write}, 0);
    chk("abort_rdata", cpu_rdata[31:0], 0);
    for (int i = 0; i < 4; i++) begin
      chk("abort_no_ready", cpu_ready, 0);
      @(negedge clk);
    end
    set_port(3, 1'b1, 20'h00063, 16'h3333, 2'b11);
    set_port(0, 1'b1, 20'h00060, 16'h0F0F, 2'b11);
    e0.port = 3; e0.rdata = 16'h0000; exp_q.push_back(e0);
    e0.port = 0; e0.rdata = 16'h0000; exp_q.push_back(e0);
    @(posedge clk); #1;
    cpu_req[3] = 1'b1;
    group_run(4'b1001, 1'b0, 2, 3);

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
